// File: rtl/dct_pkg.sv
// Shared constants, types and the 16-point DCT-II coefficient table (scaled by 2^ROM_FRAC)
// used by the DCT memory-test hierarchy.
package dct_pkg;

    localparam int ROWS     = 512;
    localparam int PIX_W    = 8;
    localparam int COEF_W   = 11;
    localparam int ROM_FRAC = 7;
    localparam int N_PT     = 16;
    localparam int ADDR_W   = $clog2(ROWS);
    localparam int ROW_W    = N_PT * PIX_W;
    localparam int OUT_W    = N_PT * COEF_W;
    // 255 * 16 * 45 < 2^18, so 20 signed bits hold any row sum without overflow.
    localparam int ACC_W    = 20;

    typedef logic [PIX_W-1:0]         pixel_t;
    typedef logic signed [COEF_W-1:0] coef_t;
    typedef logic signed [7:0]        rom_t;

    typedef enum logic [0:0] {
        ST_STREAM = 1'b0,
        ST_STOP   = 1'b1
    } state_t;

    // C[k][n] = round_half_away(128 * a_k * cos(pi*(2n+1)*k/32))
    localparam rom_t C [N_PT][N_PT] = '{
        '{8'sd32, 8'sd32, 8'sd32, 8'sd32, 8'sd32, 8'sd32, 8'sd32, 8'sd32, 8'sd32, 8'sd32, 8'sd32, 8'sd32, 8'sd32, 8'sd32, 8'sd32, 8'sd32},
        '{8'sd45, 8'sd43, 8'sd40, 8'sd35, 8'sd29, 8'sd21, 8'sd13, 8'sd4, -8'sd4, -8'sd13, -8'sd21, -8'sd29, -8'sd35, -8'sd40, -8'sd43, -8'sd45},
        '{8'sd44, 8'sd38, 8'sd25, 8'sd9, -8'sd9, -8'sd25, -8'sd38, -8'sd44, -8'sd44, -8'sd38, -8'sd25, -8'sd9, 8'sd9, 8'sd25, 8'sd38, 8'sd44},
        '{8'sd43, 8'sd29, 8'sd4, -8'sd21, -8'sd40, -8'sd45, -8'sd35, -8'sd13, 8'sd13, 8'sd35, 8'sd45, 8'sd40, 8'sd21, -8'sd4, -8'sd29, -8'sd43},
        '{8'sd42, 8'sd17, -8'sd17, -8'sd42, -8'sd42, -8'sd17, 8'sd17, 8'sd42, 8'sd42, 8'sd17, -8'sd17, -8'sd42, -8'sd42, -8'sd17, 8'sd17, 8'sd42},
        '{8'sd40, 8'sd4, -8'sd35, -8'sd43, -8'sd13, 8'sd29, 8'sd45, 8'sd21, -8'sd21, -8'sd45, -8'sd29, 8'sd13, 8'sd43, 8'sd35, -8'sd4, -8'sd40},
        '{8'sd38, -8'sd9, -8'sd44, -8'sd25, 8'sd25, 8'sd44, 8'sd9, -8'sd38, -8'sd38, 8'sd9, 8'sd44, 8'sd25, -8'sd25, -8'sd44, -8'sd9, 8'sd38},
        '{8'sd35, -8'sd21, -8'sd43, 8'sd4, 8'sd45, 8'sd13, -8'sd40, -8'sd29, 8'sd29, 8'sd40, -8'sd13, -8'sd45, -8'sd4, 8'sd43, 8'sd21, -8'sd35},
        '{8'sd32, -8'sd32, -8'sd32, 8'sd32, 8'sd32, -8'sd32, -8'sd32, 8'sd32, 8'sd32, -8'sd32, -8'sd32, 8'sd32, 8'sd32, -8'sd32, -8'sd32, 8'sd32},
        '{8'sd29, -8'sd40, -8'sd13, 8'sd45, -8'sd4, -8'sd43, 8'sd21, 8'sd35, -8'sd35, -8'sd21, 8'sd43, 8'sd4, -8'sd45, 8'sd13, 8'sd40, -8'sd29},
        '{8'sd25, -8'sd44, 8'sd9, 8'sd38, -8'sd38, -8'sd9, 8'sd44, -8'sd25, -8'sd25, 8'sd44, -8'sd9, -8'sd38, 8'sd38, 8'sd9, -8'sd44, 8'sd25},
        '{8'sd21, -8'sd45, 8'sd29, 8'sd13, -8'sd43, 8'sd35, 8'sd4, -8'sd40, 8'sd40, -8'sd4, -8'sd35, 8'sd43, -8'sd13, -8'sd29, 8'sd45, -8'sd21},
        '{8'sd17, -8'sd42, 8'sd42, -8'sd17, -8'sd17, 8'sd42, -8'sd42, 8'sd17, 8'sd17, -8'sd42, 8'sd42, -8'sd17, -8'sd17, 8'sd42, -8'sd42, 8'sd17},
        '{8'sd13, -8'sd35, 8'sd45, -8'sd40, 8'sd21, 8'sd4, -8'sd29, 8'sd43, -8'sd43, 8'sd29, -8'sd4, -8'sd21, 8'sd40, -8'sd45, 8'sd35, -8'sd13},
        '{8'sd9, -8'sd25, 8'sd38, -8'sd44, 8'sd44, -8'sd38, 8'sd25, -8'sd9, -8'sd9, 8'sd25, -8'sd38, 8'sd44, -8'sd44, 8'sd38, -8'sd25, 8'sd9},
        '{8'sd4, -8'sd13, 8'sd21, -8'sd29, 8'sd35, -8'sd40, 8'sd43, -8'sd45, 8'sd45, -8'sd43, 8'sd40, -8'sd35, 8'sd29, -8'sd21, 8'sd13, -8'sd4}
    };

endpackage

// File: rtl/dct_memory_top_dct16.sv
// 16-point integer DCT-II: combinational dot products against the package table,
// floored by ROM_FRAC bits and captured in an output register when load is high.
import dct_pkg::*;

module dct16 (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [ROW_W-1:0] pix,
    output logic [OUT_W-1:0] coef
);

    function automatic coef_t dct_row(input logic [ROW_W-1:0] row, input int k);
        logic signed [ACC_W-1:0] acc;
        logic signed [ACC_W-1:0] px;
        logic signed [ACC_W-1:0] cf;
        logic signed [ACC_W-1:0] sh;
        acc = '0;
        for (int n = 0; n < N_PT; n++) begin
            px  = $signed(ACC_W'(row[PIX_W*n +: PIX_W]));
            cf  = ACC_W'(C[k][n]);
            acc = acc + px * cf;
        end
        // Arithmetic shift floors toward minus infinity; the result always fits COEF_W.
        sh = acc >>> ROM_FRAC;
        return sh[COEF_W-1:0];
    endfunction

    coef_t X_0_trunc, X_1_trunc, X_2_trunc, X_3_trunc;
    coef_t X_4_trunc, X_5_trunc, X_6_trunc, X_7_trunc;
    coef_t X_8_trunc, X_9_trunc, X_10_trunc, X_11_trunc;
    coef_t X_12_trunc, X_13_trunc, X_14_trunc, X_15_trunc;

    assign X_0_trunc  = dct_row(pix, 0);
    assign X_1_trunc  = dct_row(pix, 1);
    assign X_2_trunc  = dct_row(pix, 2);
    assign X_3_trunc  = dct_row(pix, 3);
    assign X_4_trunc  = dct_row(pix, 4);
    assign X_5_trunc  = dct_row(pix, 5);
    assign X_6_trunc  = dct_row(pix, 6);
    assign X_7_trunc  = dct_row(pix, 7);
    assign X_8_trunc  = dct_row(pix, 8);
    assign X_9_trunc  = dct_row(pix, 9);
    assign X_10_trunc = dct_row(pix, 10);
    assign X_11_trunc = dct_row(pix, 11);
    assign X_12_trunc = dct_row(pix, 12);
    assign X_13_trunc = dct_row(pix, 13);
    assign X_14_trunc = dct_row(pix, 14);
    assign X_15_trunc = dct_row(pix, 15);

    always_ff @(posedge clk) begin
        if (rst)
            coef <= '0;
        else if (load)
            coef <= {X_15_trunc, X_14_trunc, X_13_trunc, X_12_trunc,
                     X_11_trunc, X_10_trunc, X_9_trunc,  X_8_trunc,
                     X_7_trunc,  X_6_trunc,  X_5_trunc,  X_4_trunc,
                     X_3_trunc,  X_2_trunc,  X_1_trunc,  X_0_trunc};
    end

endmodule

// File: rtl/dct_memory_top_mem.sv
// Row-wide image memory with a registered, enable-gated synchronous read port.
// Contents are not affected by reset; the bench preloads "array" directly.
import dct_pkg::*;

module dct_mem (
    input  logic              clk,
    input  logic              rst,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [ROW_W-1:0]  wdata,
    output logic [ROW_W-1:0]  rdata
);

    logic [ROW_W-1:0] array [0:ROWS-1];

    always_ff @(posedge clk) begin
        if (we)
            array[waddr] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (rst)
            rdata <= '0;
        else if (re)
            rdata <= array[raddr];
    end

endmodule

// File: rtl/dct_memory_top.sv
// DCT memory-test top: streams image rows from MEM_IN through the DCT, one row per clock.
// Define MEM_WRAP_EN to stream continuously (address wraps, done pulses once per pass).
import dct_pkg::*;

module dct_memory_top (
    input  logic             clk,
    input  logic             rstn,
    output logic [ROW_W-1:0] x_n_in,
    output logic [OUT_W-1:0] X_k_out,
    output logic             out_valid,
    output logic             done
);

`ifdef MEM_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(ROWS - 1);

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] addr;
    logic              read_req;
    logic              rd_en;
    logic              last_rd;
    logic              last_out;

    always_ff @(posedge clk) begin
        if (rstn)
            state <= ST_STREAM;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_STREAM: if (!WRAP && addr == LAST_ROW) state_next = ST_STOP;
            ST_STOP:   state_next = ST_STOP;
            default:   state_next = ST_STREAM;
        endcase
    end

    always_comb begin
        read_req = (state == ST_STREAM);
    end

    // rd_en / out_valid and last_rd / last_out follow each row through the two pipeline stages.
    always_ff @(posedge clk) begin
        if (rstn) begin
            addr      <= '0;
            rd_en     <= 1'b0;
            last_rd   <= 1'b0;
            out_valid <= 1'b0;
            last_out  <= 1'b0;
            done      <= 1'b0;
        end else begin
            if (read_req)
                addr <= (addr == LAST_ROW) ? (WRAP ? '0 : addr) : addr + 1'b1;
            rd_en     <= read_req;
            last_rd   <= read_req && (addr == LAST_ROW);
            out_valid <= rd_en;
            last_out  <= rd_en && last_rd;
            done      <= WRAP ? (out_valid && last_out) : (done || (out_valid && last_out));
        end
    end

    dct_mem MEM_IN (
        .clk   (clk),
        .rst   (rstn),
        .re    (read_req),
        .raddr (addr),
        .we    (1'b0),
        .waddr ('0),
        .wdata ('0),
        .rdata (x_n_in)
    );

    dct16 DCT (
        .clk  (clk),
        .rst  (rstn),
        .load (rd_en),
        .pix  (x_n_in),
        .coef (X_k_out)
    );

endmodule

// File: tb/tb_dct_memory_top.sv
// Bench for dct_memory_top: hand-computed single-row vectors, full-image streams against an
// independent cosine-derived model, and an abort-and-restart by reset in mid-stream.
module tb_dct_memory_top;

    localparam int NROWS = 512;
`ifdef MEM_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rstn = 1'b1;
    logic [127:0] x_n_in;
    logic [175:0] X_k_out;
    logic         out_valid;
    logic         done;

    int tests = 0;
    int fails = 0;
    int vcount;
    int gc [16][16];
    logic [127:0] img  [NROWS];
    logic [175:0] gold [NROWS];

    typedef struct {
        string        name;
        logic [127:0] row;
        int           exp_k [16];
    } vec_t;
    vec_t vecs [5];

    dct_memory_top dut (
        .clk       (clk),
        .rstn      (rstn),
        .x_n_in    (x_n_in),
        .X_k_out   (X_k_out),
        .out_valid (out_valid),
        .done      (done)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not reach its summary");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [175:0] act, input logic [175:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [175:0] pack16(input int v [16]);
        logic [175:0]       res;
        logic signed [31:0] t;
        res = '0;
        for (int k = 0; k < 16; k++) begin
            t = v[k];
            res[11*k +: 11] = t[10:0];
        end
        return res;
    endfunction

    function automatic logic [175:0] golden(input logic [127:0] row);
        logic [175:0]       res;
        int                 acc;
        logic signed [31:0] q;
        res = '0;
        for (int k = 0; k < 16; k++) begin
            acc = 0;
            for (int n = 0; n < 16; n++)
                acc += int'(row[8*n +: 8]) * gc[k][n];
            q = acc >>> 7;
            res[11*k +: 11] = q[10:0];
        end
        return res;
    endfunction

    task automatic build_coefs();
        real a;
        real v;
        for (int k = 0; k < 16; k++) begin
            for (int n = 0; n < 16; n++) begin
                a = (k == 0) ? 0.25 : ($sqrt(2.0) / 4.0);
                v = 128.0 * a * $cos(3.14159265358979 * real'((2*n + 1) * k) / 32.0);
                gc[k][n] = (v >= 0.0) ? int'($floor(v + 0.5)) : -int'($floor(-v + 0.5));
            end
        end
    endtask

    task automatic load_image();
        for (int r = 0; r < NROWS; r++) begin
            dut.MEM_IN.array[r] = img[r];
            gold[r] = (r < 5) ? pack16(vecs[r].exp_k) : golden(img[r]);
        end
    endtask

    task automatic hold_reset();
        rstn = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    // Called at a negedge with rstn just released; cycle k is sampled after the k-th active edge.
    task automatic run_pass(input int n);
        for (int k = 1; k <= n; k++) begin
            int           orow;
            int           xrow;
            logic         ev;
            logic         ed;
            logic [175:0] ex;
            @(negedge clk);
            ev   = WRAP ? (k >= 2) : (k >= 2 && k <= NROWS + 1);
            ed   = WRAP ? (k >= NROWS + 2 && (k - NROWS - 2) % NROWS == 0) : (k >= NROWS + 2);
            xrow = WRAP ? (k - 1) % NROWS : ((k - 1 > NROWS - 1) ? NROWS - 1 : k - 1);
            if (k < 2) begin
                ex = '0;
            end else begin
                orow = WRAP ? (k - 2) % NROWS : ((k - 2 > NROWS - 1) ? NROWS - 1 : k - 2);
                ex = gold[orow];
            end
            check($sformatf("x_n_in c%0d", k), x_n_in, img[xrow]);
            check($sformatf("out_valid c%0d", k), out_valid, ev);
            check($sformatf("done c%0d", k), done, ed);
            check($sformatf("X_k_out c%0d", k), X_k_out, ex);
            if (out_valid)
                vcount++;
        end
    endtask

    initial begin
        build_coefs();

        vecs[0].name = "zeros";   vecs[0].row = '0;
        vecs[0].exp_k = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        vecs[1].name = "all_255"; vecs[1].row = {16{8'hFF}};
        vecs[1].exp_k = '{1020, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        vecs[2].name = "p0_255";  vecs[2].row = {120'd0, 8'hFF};
        vecs[2].exp_k = '{63, 89, 87, 85, 83, 79, 75, 69, 63, 57, 49, 41, 33, 25, 17, 7};
        vecs[3].name = "p15_255"; vecs[3].row = {8'hFF, 120'd0};
        vecs[3].exp_k = '{63, -90, 87, -86, 83, -80, 75, -70, 63, -58, 49, -42, 33, -26, 17, -8};
        vecs[4].name = "all_1";   vecs[4].row = {16{8'h01}};
        vecs[4].exp_k = '{4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};

        // Reset state
        for (int r = 0; r < NROWS; r++) img[r] = '0;
        load_image();
        repeat (3) @(negedge clk);
        check("reset x_n_in", x_n_in, '0);
        check("reset X_k_out", X_k_out, '0);
        check("reset out_valid", out_valid, 1'b0);
        check("reset done", done, 1'b0);

        // Single-row vectors: row 0 appears on X_k_out two edges after release
        for (int i = 0; i < 5; i++) begin
            hold_reset();
            dut.MEM_IN.array[0] = vecs[i].row;
            rstn = 1'b0;
            @(negedge clk);
            check({vecs[i].name, " x_n_in"}, x_n_in, vecs[i].row);
            @(negedge clk);
            check({vecs[i].name, " out_valid"}, out_valid, 1'b1);
            check({vecs[i].name, " X_k_out"}, X_k_out, pack16(vecs[i].exp_k));
        end

        // All-zero image, full pass
        hold_reset();
        for (int r = 0; r < NROWS; r++) img[r] = '0;
        for (int r = 0; r < 5; r++) vecs[r].row = (r == 0) ? vecs[r].row : vecs[r].row;
        for (int r = 0; r < NROWS; r++) begin
            dut.MEM_IN.array[r] = '0;
            gold[r] = '0;
        end
        rstn = 1'b0;
        vcount = 0;
        run_pass(530);
        check("zero pass valid count", 32'(vcount), WRAP ? 32'd529 : 32'd512);

        // Random image with the hand vectors in rows 0..4
        hold_reset();
        for (int r = 0; r < NROWS; r++)
            img[r] = (r < 5) ? vecs[r].row : {$urandom, $urandom, $urandom, $urandom};
        load_image();
        rstn = 1'b0;
        vcount = 0;
        run_pass(530);
        check("random pass valid count", 32'(vcount), WRAP ? 32'd529 : 32'd512);

        // Reset sampled at the edge that would have read row 200, then a clean restart
        hold_reset();
        rstn = 1'b0;
        vcount = 0;
        run_pass(200);
        rstn = 1'b1;
        @(negedge clk);
        check("abort x_n_in", x_n_in, '0);
        check("abort X_k_out", X_k_out, '0);
        check("abort out_valid", out_valid, 1'b0);
        check("abort done", done, 1'b0);
        rstn = 1'b0;
        vcount = 0;
        run_pass(530);
        check("restart pass valid count", 32'(vcount), WRAP ? 32'd529 : 32'd512);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
